// File: rtl/aes_cipher_core_if.sv
// Block-in / block-out handshake bundle for aes_cipher_core.
// The producer/consumer side takes the master modport and the core takes the slave modport.
interface aes_cipher_core_if #(
  parameter int unsigned nr = 10
);
  logic [128*(nr+1)-1:0] expandedKeys;
  logic [127:0]          plainText;
  logic                  inValid;
  logic                  inReady;
  logic [127:0]          cipherText;
  logic                  outValid;
  logic                  outReady;

  modport master (
    output expandedKeys, plainText, inValid, outReady,
    input  inReady, cipherText, outValid
  );

  modport slave (
    input  expandedKeys, plainText, inValid, outReady,
    output inReady, cipherText, outValid
  );
endinterface

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one full round per clock.
// The key schedule is supplied pre-expanded and is read live every round.
module aes_cipher_core #(
  parameter int unsigned nk = 4,
  parameter int unsigned nr = 10
) (
  input logic             clk,
  input logic             rst_n,
  aes_cipher_core_if.slave bus
);

  localparam int unsigned KW = 128*(nr+1);

  if (nr != nk + 6) begin : g_cfg_error
    $error("aes_cipher_core: nr must equal nk+6");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         state_q, state_d;
  logic [3:0]   round_cnt;
  logic [127:0] st_q;
  logic [127:0] ct_q;
  logic [127:0] rkey;
  logic [127:0] sb, sr, mc;
  logic         last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // round_cnt is 0 in IDLE, so the same mux serves the initial AddRoundKey.
  always_comb begin
    rkey = '0;
    for (int unsigned r = 0; r <= nr; r++)
      if (round_cnt == 4'(r)) rkey = bus.expandedKeys[KW-1-128*r -: 128];
  end

  always_comb begin
    sb   = sub_bytes(st_q);
    sr   = shift_rows(sb);
    mc   = mix_columns(sr);
    last = (round_cnt == 4'(nr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.inValid)  state_d = ROUND;
      ROUND:   if (last)         state_d = DONE;
      DONE:    if (bus.outReady) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.inReady    = (state_q == IDLE);
    bus.outValid   = (state_q == DONE);
    bus.cipherText = ct_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= '0;
      ct_q      <= '0;
      round_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.inValid) begin
          st_q      <= bus.plainText ^ rkey;
          round_cnt <= 4'd1;
        end
        ROUND: if (!last) begin
          st_q      <= mc ^ rkey;
          round_cnt <= round_cnt + 4'd1;
        end else begin
          ct_q <= sr ^ rkey;
        end
        DONE: if (bus.outReady) round_cnt <= '0;
        default: round_cnt <= '0;
      endcase
    end
  end

endmodule
